// File: rtl/single_cycle_cpu.sv
// single_cycle_cpu: single-cycle 64-bit LEGv8 subset core with built-in ROM, register file and data memory
module single_cycle_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [63:0] startPC,
  output logic [63:0] currentPC,
  output logic [63:0] dMemOut
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [63:0] pc_q, pc_d, dmem_out_q, dmem_out_d;
  logic [63:0] regs_q [32];
  logic [63:0] dmem_q [DMEM_WORDS];
  logic [31:0] rom [IMEM_WORDS];
  logic [31:0] inst;
  logic [4:0]  rn, rm, rd, rb_idx;
  logic [63:0] a, b, imm12, alu_y, ld_data, wd, offset;
  logic [AW-1:0] dm_idx;
  logic is_add, is_sub, is_and, is_orr, is_addi, is_subi, is_ldur, is_stur, is_cbz, is_cbnz, is_b;
  logic we, taken;
  always_comb begin
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = '0;
    rom[0]  = 32'h910017E1;
    rom[1]  = 32'h91000FE2;
    rom[2]  = 32'hCB020023;
    rom[3]  = 32'hF80083E3;
    rom[4]  = 32'hB400005F;
    rom[5]  = 32'h91001C63;
    rom[6]  = 32'hF84083E4;
    rom[7]  = 32'h8A010085;
    rom[8]  = 32'hAA050086;
    rom[9]  = 32'hB500009F;
    rom[10] = 32'hF80103E6;
    rom[11] = 32'h14000001;
    rom[12] = 32'h14000000;
  end
  assign inst    = (pc_q < 64'(IMEM_WORDS) * 64'd4) ? rom[pc_q[7:2]] : '0;
  assign rn      = inst[9:5];
  assign rm      = inst[20:16];
  assign rd      = inst[4:0];
  assign is_add  = inst[31:21] == 11'b10001011000;
  assign is_sub  = inst[31:21] == 11'b11001011000;
  assign is_and  = inst[31:21] == 11'b10001010000;
  assign is_orr  = inst[31:21] == 11'b10101010000;
  assign is_addi = inst[31:22] == 10'b1001000100;
  assign is_subi = inst[31:22] == 10'b1101000100;
  assign is_ldur = inst[31:21] == 11'b11111000010;
  assign is_stur = inst[31:21] == 11'b11111000000;
  assign is_cbz  = inst[31:24] == 8'b10110100;
  assign is_cbnz = inst[31:24] == 8'b10110101;
  assign is_b    = inst[31:26] == 6'b000101;
  // Stores and compare-branches read Rt through the second port
  assign rb_idx  = (is_stur || is_cbz || is_cbnz) ? rd : rm;
  assign a       = (rn == 5'd31) ? '0 : regs_q[rn];
  assign b       = (rb_idx == 5'd31) ? '0 : regs_q[rb_idx];
  assign imm12   = {52'b0, inst[21:10]};
  assign dm_idx  = AW'((a[7:0] + inst[19:12]) >> 3);
  assign ld_data = dmem_q[dm_idx];
  always_comb begin
    alu_y      = is_add ? a + b : is_sub ? a - b : is_and ? a & b : is_orr ? a | b :
                 is_addi ? a + imm12 : a - imm12;
    we         = is_add || is_sub || is_and || is_orr || is_addi || is_subi || is_ldur;
    wd         = is_ldur ? ld_data : alu_y;
    taken      = is_b || (is_cbz && b == '0) || (is_cbnz && b != '0);
    offset     = is_b ? {{36{inst[25]}}, inst[25:0], 2'b00} : {{43{inst[23]}}, inst[23:5], 2'b00};
    pc_d       = taken ? pc_q + offset : pc_q + 64'd4;
    dmem_out_d = is_ldur ? ld_data : is_stur ? b : dmem_out_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q       <= startPC;
      dmem_out_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      dmem_out_q <= dmem_out_d;
      if (we && rd != 5'd31) regs_q[rd] <= wd;
      if (is_stur) dmem_q[dm_idx] <= b;
    end
  end
  assign currentPC = pc_q;
  assign dMemOut   = dmem_out_q;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb_single_cycle_cpu: directed and random-reset checks against an assembly-level program model
module tb_single_cycle_cpu;
  logic        Clk = 0, Rst = 1;
  logic [63:0] startPC = '0;
  logic [63:0] currentPC, dMemOut;
  int checks = 0, errors = 0;

  single_cycle_cpu dut (.Clk(Clk), .Rst(Rst), .startPC(startPC), .currentPC(currentPC), .dMemOut(dMemOut));

  always #5 Clk = ~Clk;

  typedef enum {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B} op_t;
  typedef struct {op_t op; int d; int n; int m; longint imm;} ins_t;
  ins_t prog [13];

  longint unsigned mr [32];
  longint unsigned mm [32];
  longint unsigned mpc, mout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned rd_reg(input int i);
    return (i == 31) ? 64'd0 : mr[i];
  endfunction

  function automatic void wr_reg(input int i, input longint unsigned v);
    if (i != 31) mr[i] = v;
  endfunction

  function automatic void mstep(input bit rst, input longint unsigned spc);
    ins_t in;
    longint unsigned addr, nxt;
    if (rst) begin
      mpc = spc; mout = 0;
      for (int i = 0; i < 32; i++) begin mr[i] = 0; mm[i] = 0; end
      return;
    end
    in = '{OP_NOP, 0, 0, 0, 0};
    if (mpc < 256 && (mpc >> 2) < 13) in = prog[mpc >> 2];
    addr = rd_reg(in.n) + 64'(in.imm);
    nxt = mpc + 4;
    case (in.op)
      OP_ADD:  wr_reg(in.d, rd_reg(in.n) + rd_reg(in.m));
      OP_SUB:  wr_reg(in.d, rd_reg(in.n) - rd_reg(in.m));
      OP_AND:  wr_reg(in.d, rd_reg(in.n) & rd_reg(in.m));
      OP_ORR:  wr_reg(in.d, rd_reg(in.n) | rd_reg(in.m));
      OP_ADDI: wr_reg(in.d, rd_reg(in.n) + 64'(in.imm));
      OP_SUBI: wr_reg(in.d, rd_reg(in.n) - 64'(in.imm));
      OP_LDUR: begin mout = mm[(addr % 256) / 8]; wr_reg(in.d, mout); end
      OP_STUR: begin mout = rd_reg(in.d); mm[(addr % 256) / 8] = mout; end
      OP_CBZ:  if (rd_reg(in.d) == 0) nxt = mpc + 64'(in.imm * 4);
      OP_CBNZ: if (rd_reg(in.d) != 0) nxt = mpc + 64'(in.imm * 4);
      OP_B:    nxt = mpc + 64'(in.imm * 4);
      default: ;
    endcase
    mpc = nxt;
  endfunction

  task automatic tick(input bit r, input logic [63:0] s);
    Rst = r; startPC = s;
    @(posedge Clk);
    mstep(r, s);
    #1;
    chk("pc", currentPC, mpc);
    chk("dmem_out", dMemOut, mout);
  endtask

  logic [63:0] exp_seq [11];
  logic [63:0] spc;
  int n;

  initial begin
    prog[0]  = '{OP_ADDI, 1, 31, 0, 5};
    prog[1]  = '{OP_ADDI, 2, 31, 0, 3};
    prog[2]  = '{OP_SUB,  3, 1, 2, 0};
    prog[3]  = '{OP_STUR, 3, 31, 0, 8};
    prog[4]  = '{OP_CBZ,  31, 0, 0, 2};
    prog[5]  = '{OP_ADDI, 3, 3, 0, 7};
    prog[6]  = '{OP_LDUR, 4, 31, 0, 8};
    prog[7]  = '{OP_AND,  5, 4, 1, 0};
    prog[8]  = '{OP_ORR,  6, 4, 5, 0};
    prog[9]  = '{OP_CBNZ, 31, 0, 0, 4};
    prog[10] = '{OP_STUR, 6, 31, 0, 16};
    prog[11] = '{OP_B,    0, 0, 0, 1};
    prog[12] = '{OP_B,    0, 0, 0, 0};
    exp_seq = '{64'h04, 64'h08, 64'h0C, 64'h10, 64'h18, 64'h1C, 64'h20, 64'h24, 64'h28, 64'h2C, 64'h30};

    tick(1, 64'h0);
    chk("rst_pc", currentPC, 64'h0);
    chk("rst_dmem", dMemOut, 64'h0);
    for (int i = 0; i < 11; i++) begin
      tick(0, 64'h0);
      chk("seq_pc", currentPC, exp_seq[i]);
      if (i == 2) chk("x3_after_sub", dut.regs_q[3], 64'd2);
    end
    chk("halt_dmem", dMemOut, 64'd2);
    for (int i = 0; i < 10; i++) begin
      tick(0, 64'h0);
      chk("hold_pc", currentPC, 64'h30);
      chk("hold_dmem", dMemOut, 64'd2);
    end
    chk("x3", dut.regs_q[3], 64'd2);
    chk("x4", dut.regs_q[4], 64'd2);
    chk("x5", dut.regs_q[5], 64'd0);
    chk("x6", dut.regs_q[6], 64'd2);
    chk("mem1", dut.dmem_q[1], 64'd2);
    chk("mem2", dut.dmem_q[2], 64'd2);

    tick(1, 64'h18);
    chk("rst18_pc", currentPC, 64'h18);
    tick(0, 64'h0);
    chk("ldur_cleared", dMemOut, 64'd0);
    n = 0;
    while (currentPC != 64'h30 && n < 20) begin tick(0, 64'h0); n++; end
    chk("rst18_end_pc", currentPC, 64'h30);
    chk("rst18_end_dmem", dMemOut, 64'd0);

    tick(1, 64'h0);
    n = 0;
    while (currentPC != 64'h1C && n < 20) begin tick(0, 64'h0); n++; end
    chk("reach_1c", currentPC, 64'h1C);
    tick(1, 64'h40);
    chk("mid_rst_pc", currentPC, 64'h40);
    chk("mid_rst_dmem", dMemOut, 64'd0);
    chk("mid_rst_x1", dut.regs_q[1], 64'd0);
    chk("mid_rst_x3", dut.regs_q[3], 64'd0);

    tick(1, 64'h0);
    repeat (1000) tick(0, 64'h0);
    chk("wdog_pc", currentPC, 64'h30);
    chk("wdog_dmem", dMemOut, 64'd2);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: spc = 64'(4 * $urandom_range(0, 15));
        7: spc = 64'($urandom_range(0, 255));
        8: spc = 64'h100 + 64'($urandom_range(0, 64));
        default: spc = {$urandom, $urandom};
      endcase
      tick($urandom_range(0, 39) == 0, spc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
